// File: rtl/pll_md_ctrl_pkg.sv
// Shared types for the PLL MD-port master: bus opcodes, host commands and FSM states.
// No logic here, so there is no latency and no backpressure.
package pll_md_pkg;

    typedef enum logic [1:0] {
        OPC_NOP   = 2'b00,
        OPC_WRITE = 2'b01,
        OPC_READ  = 2'b10,
        OPC_ADDR  = 2'b11
    } md_opc_t;

    typedef enum logic [1:0] {
        CMD_WRITE = 2'b00,
        CMD_READ  = 2'b01,
        CMD_APPLY = 2'b10,
        CMD_RSVD  = 2'b11
    } md_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_RWAIT,
        ST_RST,
        ST_LOCK_WAIT,
        ST_DONE
    } md_state_t;

    // States that occupy a two-cycle MD phase and run the mdclk toggle.
    function automatic logic is_md_phase(input md_state_t st);
        return (st == ST_ADDR) || (st == ST_DATA) || (st == ST_RWAIT);
    endfunction

endpackage

// File: rtl/pll_md_ctrl_if.sv
// Host command port of the PLL MD master: req/ready handshake, command bus, completion status.
// master = host side, slave = controller side.
interface pll_md_ctrl_if;
    logic       req;
    logic       ready;
    logic [1:0] cmd;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       done;
    logic       err;

    modport master (
        output req, cmd, addr, wdata,
        input  ready, rdata, done, err
    );

    modport slave (
        input  req, cmd, addr, wdata,
        output ready, rdata, done, err
    );
endinterface

// File: rtl/pll_md_ctrl_sync_2ff.sv
// Two-flop synchronizer for the asynchronous PLL lock; clr_i flushes both stages.
// Latency: 2 clk cycles; no backpressure.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else if (clr_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/pll_md_ctrl.sv
// PLL MD-port master: write/read as ADDR+DATA(+RWAIT) MD phases, apply = reset pulse + lock wait.
// Latency: write done in cycle 5, read in cycle 7, apply 3 cycles after lock; ready low while busy.
// Build option PLL_MD_LOCK_TIMEOUT_EN bounds the lock wait and reports expiry on err.
module pll_md_ctrl
    import pll_md_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT = 65535
) (
    input  logic         clk,
    input  logic         rst_n,
    pll_md_ctrl_if.slave host,
    output logic         pll_reset,
    input  logic         lock,
    output logic         mdclk,
    output logic [1:0]   mdopc,
    output logic         mdainc,
    output logic [7:0]   mdwdi,
    input  logic [7:0]   mdrdo
);

    localparam int unsigned      RCNT_W    = $clog2(RESET_CYCLES + 1);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(RESET_CYCLES - 1);

    if (RESET_CYCLES < 1 || LOCK_TIMEOUT < 1) begin : g_param_check
        $error("pll_md_ctrl: RESET_CYCLES and LOCK_TIMEOUT must be at least 1");
    end

    md_state_t         state_q;
    md_cmd_t           cmd_q;
    md_opc_t           mdopc_q;
    logic [7:0]        wdata_q;
    logic [7:0]        rdata_q;
    logic [7:0]        mdwdi_q;
    logic              ready_q;
    logic              done_q;
    logic              prst_q;
    logic              mdclk_q;
    logic [RCNT_W-1:0] rcnt_q;
    logic              lock_s;

`ifdef PLL_MD_LOCK_TIMEOUT_EN
    localparam int unsigned      TMO_W    = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;
`endif

    // Held clear outside LOCK_WAIT so a lock that is already high is still resampled on entry.
    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_q != ST_LOCK_WAIT),
        .d_i   (lock),
        .q_o   (lock_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_RSVD;
            mdopc_q <= OPC_NOP;
            wdata_q <= 8'h00;
            rdata_q <= 8'h00;
            mdwdi_q <= 8'h00;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            prst_q  <= 1'b0;
            mdclk_q <= 1'b0;
            rcnt_q  <= '0;
`ifdef PLL_MD_LOCK_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            // mdclk_q doubles as the phase bit: 0 = first cycle, 1 = second cycle of a phase.
            if (is_md_phase(state_q)) begin
                mdclk_q <= ~mdclk_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (host.req && ready_q) begin
                        cmd_q   <= md_cmd_t'(host.cmd);
                        wdata_q <= host.wdata;
                        ready_q <= 1'b0;
`ifdef PLL_MD_LOCK_TIMEOUT_EN
                        err_q   <= 1'b0;
`endif
                        case (md_cmd_t'(host.cmd))
                            CMD_WRITE, CMD_READ: begin
                                state_q <= ST_ADDR;
                                mdopc_q <= OPC_ADDR;
                                mdwdi_q <= host.addr;
                            end
                            CMD_APPLY: begin
                                state_q <= ST_RST;
                                prst_q  <= 1'b1;
                                rcnt_q  <= '0;
                            end
                            default: begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_ADDR: begin
                    if (mdclk_q) begin
                        state_q <= ST_DATA;
                        if (cmd_q == CMD_WRITE) begin
                            mdopc_q <= OPC_WRITE;
                            mdwdi_q <= wdata_q;
                        end else begin
                            mdopc_q <= OPC_READ;
                            mdwdi_q <= 8'h00;
                        end
                    end
                end

                ST_DATA: begin
                    if (mdclk_q) begin
                        mdopc_q <= OPC_NOP;
                        mdwdi_q <= 8'h00;
                        if (cmd_q == CMD_WRITE) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RWAIT;
                        end
                    end
                end

                ST_RWAIT: begin
                    if (mdclk_q) begin
                        rdata_q <= mdrdo;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end

                ST_RST: begin
                    if (rcnt_q == RCNT_LAST) begin
                        prst_q  <= 1'b0;
                        state_q <= ST_LOCK_WAIT;
`ifdef PLL_MD_LOCK_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end else begin
                        rcnt_q <= rcnt_q + 1'b1;
                    end
                end

                ST_LOCK_WAIT: begin
                    if (lock_s) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
`ifdef PLL_MD_LOCK_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end

                ST_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end

                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Gating with rst_n keeps ready low throughout reset yet high straight after release.
    assign host.ready = ready_q & rst_n;
    assign host.done  = done_q;
    assign host.rdata = rdata_q;
`ifdef PLL_MD_LOCK_TIMEOUT_EN
    assign host.err   = err_q;
`else
    assign host.err   = 1'b0;
`endif

    assign pll_reset = prst_q;
    assign mdclk     = mdclk_q;
    assign mdopc     = mdopc_q;
    assign mdwdi     = mdwdi_q;
    assign mdainc    = 1'b0;

endmodule

// File: tb/tb_pll_md_ctrl.sv
// Scoreboard bench for pll_md_ctrl: stimulus pushes expected MD ops, pll_reset pulses and dones;
// a PLL register model and a negedge monitor pop and compare.
module tb_pll_md_ctrl;
    import pll_md_pkg::*;

    localparam int RC = 16;
    localparam int LT = 100;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_reset;
    logic       lock = 1'b0;
    logic       mdclk;
    logic [1:0] mdopc;
    logic       mdainc;
    logic [7:0] mdwdi;
    logic [7:0] mdrdo = 8'h00;

    pll_md_ctrl_if host ();

    pll_md_ctrl #(.RESET_CYCLES(RC), .LOCK_TIMEOUT(LT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .host      (host),
        .pll_reset (pll_reset),
        .lock      (lock),
        .mdclk     (mdclk),
        .mdopc     (mdopc),
        .mdainc    (mdainc),
        .mdwdi     (mdwdi),
        .mdrdo     (mdrdo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct { int cyc; logic [7:0] rdata; logic err; } done_exp_t;
    typedef struct { int cyc; logic [1:0] opc; logic [7:0] wdi; } md_exp_t;

    done_exp_t done_q[$];
    md_exp_t   md_q[$];
    int        prst_q[$];

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;

    logic [7:0] ref_mem [256];
    logic [7:0] pll_regs [256];
    logic [7:0] last_rdata = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] init_val(input int i);
        if (i == 8'h12) return 8'hA7;
        return 8'(i * 37 + 11);
    endfunction

    // PLL register model: acts on each mdclk rise and checks it against the expected op.
    initial begin
        md_exp_t me;
        logic [7:0] ptr;
        ptr = 8'h00;
        for (int i = 0; i < 256; i++) pll_regs[i] = init_val(i);
        forever begin
            @(posedge mdclk);
            case (mdopc)
                2'b11:   ptr = mdwdi;
                2'b01:   pll_regs[ptr] = mdwdi;
                2'b10:   mdrdo = pll_regs[ptr];
                default: ;
            endcase
            if (md_q.size() == 0) begin
                chk("md_unexpected_op", {mdopc, mdwdi}, 32'hFFFF_FFFF);
            end else begin
                me = md_q.pop_front();
                chk("md_rise_cyc", cyc, me.cyc);
                chk("md_opc", mdopc, me.opc);
                chk("md_wdi", mdwdi, me.wdi);
            end
        end
    end

    done_exp_t  de;
    logic       prev_done = 1'b0;
    logic       prev_prst = 1'b0;
    logic [1:0] prev_opc = 2'b00;
    logic [7:0] prev_wdi = 8'h00;
    int         prst_start = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
            prev_prst = 1'b0;
        end else begin
            chk("mdainc", mdainc, 0);
            if (mdclk) chk("md_hold_while_high", {mdopc, mdwdi}, {prev_opc, prev_wdi});
            if (host.ready) chk("idle_bus", {mdclk, mdopc, mdwdi}, 0);
            if (prev_done) chk("ready_after_done", host.ready, 1);
            if (host.done) begin
                done_cnt++;
                chk("ready_in_done", host.ready, 0);
                if (done_q.size() == 0) begin
                    chk("done_unexpected", host.done, 0);
                end else begin
                    de = done_q.pop_front();
                    chk("done_cyc", cyc, de.cyc);
                    chk("rdata", host.rdata, de.rdata);
                    chk("err", host.err, de.err);
                end
            end
            if (pll_reset && !prev_prst) begin
                prst_start = cyc;
                if (prst_q.size() == 0) chk("prst_unexpected", pll_reset, 0);
                else chk("prst_start", cyc, prst_q.pop_front());
            end
            if (!pll_reset && prev_prst) chk("prst_len", cyc - prst_start, RC);
            prev_done = host.done;
            prev_prst = pll_reset;
            prev_opc  = mdopc;
            prev_wdi  = mdwdi;
        end
    end

    // Handshake one command; b is the cycle numbering base (spec cycle k is seen at cyc == b + k).
    task automatic issue(input logic [1:0] c, input logic [7:0] a, input logic [7:0] w, output int b);
        int n;
        n = 0;
        b = 0;
        @(negedge clk);
        while (!host.ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", host.ready, 1);
        if (!host.ready) return;
        host.req   = 1'b1;
        host.cmd   = c;
        host.addr  = a;
        host.wdata = w;
        @(posedge clk);
        #1;
        b = cyc - 1;
        host.req = 1'b0;
        case (c)
            2'd0: begin
                md_q.push_back('{b + 2, 2'b11, a});
                md_q.push_back('{b + 4, 2'b01, w});
                ref_mem[a] = w;
                done_q.push_back('{b + 5, last_rdata, 1'b0});
            end
            2'd1: begin
                md_q.push_back('{b + 2, 2'b11, a});
                md_q.push_back('{b + 4, 2'b10, 8'h00});
                md_q.push_back('{b + 6, 2'b00, 8'h00});
                last_rdata = ref_mem[a];
                done_q.push_back('{b + 7, last_rdata, 1'b0});
            end
            2'd2: begin
                lock = 1'b0;
                prst_q.push_back(b + 1);
            end
            default: done_q.push_back('{b + 1, last_rdata, 1'b0});
        endcase
    endtask

    // Apply with lock rising at #1 after relative edge RC+d; d<0 means during the reset pulse.
    task automatic apply_run(input int d);
        int b;
        issue(2'd2, 8'h00, 8'h00, b);
        done_q.push_back('{b + RC + ((d > 0) ? d : 0) + 4, last_rdata, 1'b0});
        repeat (RC + d) @(posedge clk);
        #1;
        lock = 1'b1;
    endtask

    task automatic hard_reset();
        done_q.delete();
        md_q.delete();
        prst_q.delete();
        rst_n = 1'b0;
        #1;
        chk("rst_pll_reset", pll_reset, 0);
        chk("rst_mdopc", mdopc, 0);
        chk("rst_done", host.done, 0);
        chk("rst_ready", host.ready, 0);
        lock = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", host.ready, 1);
        last_rdata = 8'h00;
    endtask

    initial begin
        int b;
        int n0;
        logic [1:0] c;
        host.req = 1'b0;
        host.cmd = 2'd0;
        host.addr = 8'h00;
        host.wdata = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);

        repeat (2) @(negedge clk);
        chk("reset_ready", host.ready, 0);
        chk("reset_done", host.done, 0);
        chk("reset_err", host.err, 0);
        chk("reset_rdata", host.rdata, 0);
        chk("reset_pll_reset", pll_reset, 0);
        chk("reset_md_bus", {mdclk, mdainc, mdopc, mdwdi}, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_first_cycle", host.ready, 1);

        issue(2'd0, 8'h05, 8'h3C, b);
        issue(2'd1, 8'h12, 8'h00, b);
        apply_run(10);
        issue(2'd3, 8'h44, 8'h55, b);

        // Second request during the busy window must be dropped.
        issue(2'd0, 8'h21, 8'h9E, b);
        repeat (2) @(negedge clk);
        host.req = 1'b1;
        host.cmd = 2'd1;
        @(negedge clk);
        host.req = 1'b0;
        issue(2'd1, 8'h21, 8'h00, b);

        for (int k = 0; k < 40; k++) begin
            c = 2'($urandom_range(0, 3));
            if (c == 2'd2) apply_run(int'($urandom_range(0, 16)) - 4);
            else issue(c, 8'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), b);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        // Lock never arrives.
        issue(2'd2, 8'h00, 8'h00, b);
`ifdef PLL_MD_LOCK_TIMEOUT_EN
        done_q.push_back('{b + RC + LT + 1, last_rdata, 1'b1});
        issue(2'd0, 8'h03, 8'h81, b);
`else
        n0 = done_cnt;
        repeat (1000) @(negedge clk);
        chk("no_done_without_lock", done_cnt - n0, 0);
        hard_reset();
`endif

        // Reset in cycle 5 of an apply aborts it with no done.
        issue(2'd2, 8'h00, 8'h00, b);
        repeat (5) @(negedge clk);
        chk("prst_before_abort", pll_reset, 1);
        #2;
        hard_reset();
        n0 = done_cnt;
        repeat (30) @(negedge clk);
        chk("no_done_after_abort", done_cnt - n0, 0);

        issue(2'd1, 8'h05, 8'h00, b);
        n0 = 0;
        while (!host.ready && n0 < 400) begin
            @(negedge clk);
            n0++;
        end
        repeat (3) @(negedge clk);
        chk("done_queue_drained", done_q.size(), 0);
        chk("md_queue_drained", md_q.size(), 0);
        chk("prst_queue_drained", prst_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
